// File: rtl/z80_pads_pkg.sv
// ---------------------------------------------------------------------------
// z80_pads_pkg
// Shared definitions for the Z80 pad-input conditioning slice:
//   - rst_state_e  : reset sequencer states (hold, release sync, stretch, run)
//   - PIN_INACTIVE : idle level of the active-low Z80 control pins
//   - DEF_*        : default values for the conditioning parameters
//   - cnt_width()  : width of a down-counter able to hold a given maximum
// ---------------------------------------------------------------------------
package z80_pads_pkg;

    // Reset sequencer states. The S_ prefix keeps the literals distinct from
    // the RST_STRETCH parameter of the top level.
    typedef enum logic [1:0] {
        S_RST_HOLD    = 2'd0,
        S_RST_SYNC    = 2'd1,
        S_RST_STRETCH = 2'd2,
        S_RUN         = 2'd3
    } rst_state_e;

    // Idle level of every active-low Z80 control pin.
    localparam logic PIN_INACTIVE = 1'b1;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_RST_STRETCH = 8;
    localparam int DEF_NMI_FILTER  = 4;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/z80_sync_cell.sv
// ---------------------------------------------------------------------------
// z80_sync_cell
// Generic multi-flop synchroniser chain with an asynchronous active-low
// reset to a parameterised level.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, forces every stage to RESET_VAL
//   i_d     : asynchronous input
//   o_q     : synchronised output (last stage), latency STAGES rising edges
// ---------------------------------------------------------------------------
module z80_sync_cell
    import z80_pads_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = PIN_INACTIVE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift register: stage 0 captures the raw input, the last stage is the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/z80_input_cond.sv
// ---------------------------------------------------------------------------
// z80_input_cond
// Conditioning stage between the input pads and the Z80 core: synchronises
// nWAIT/nINT/nNMI/nBUSRQ into CLK, optionally glitch-filters nNMI, and
// produces a core reset that asserts asynchronously and releases
// synchronously after a programmable stretch.
//
// Ports:
//   CLK       in  core clock
//   nRESET    in  pad reset, asynchronous active-low
//   nWAIT_I   in  raw pad input        nWAIT_S   out synchronised nWAIT
//   nINT_I    in  raw pad input        nINT_S    out synchronised nINT
//   nNMI_I    in  raw pad input        nNMI_S    out synchronised/filtered nNMI
//   nBUSRQ_I  in  raw pad input        nBUSRQ_S  out synchronised nBUSRQ
//   nRESET_S  out conditioned core reset, active-low, flop-driven
//   rst_busy  out high while the reset sequencer is not in RUN
//
// Build option: define Z80_NMI_FILTER_EN to insert the nNMI glitch filter
// (NMI_FILTER consecutive differing samples before nNMI_S changes). Without
// it nNMI_S is the plain synchroniser output and NMI_FILTER has no effect.
// ---------------------------------------------------------------------------
module z80_input_cond
    import z80_pads_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int RST_STRETCH = DEF_RST_STRETCH,
    parameter int NMI_FILTER  = DEF_NMI_FILTER
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic nWAIT_I,
    input  logic nINT_I,
    input  logic nNMI_I,
    input  logic nBUSRQ_I,
    output logic nWAIT_S,
    output logic nINT_S,
    output logic nNMI_S,
    output logic nBUSRQ_S,
    output logic nRESET_S,
    output logic rst_busy
);

    localparam int              CNT_W    = cnt_width(RST_STRETCH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_STRETCH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic w_nmi_sync;
    logic w_rel_sync;

    // ------------------------------------------------------------------
    // Input synchronisers (idle high) and the reset-release chain (idle low,
    // shifting in ones once nRESET is high).
    // ------------------------------------------------------------------
    z80_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(PIN_INACTIVE)) u_sync_wait (
        .i_clk(CLK), .i_rst_n(nRESET), .i_d(nWAIT_I), .o_q(nWAIT_S)
    );

    z80_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(PIN_INACTIVE)) u_sync_int (
        .i_clk(CLK), .i_rst_n(nRESET), .i_d(nINT_I), .o_q(nINT_S)
    );

    z80_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(PIN_INACTIVE)) u_sync_nmi (
        .i_clk(CLK), .i_rst_n(nRESET), .i_d(nNMI_I), .o_q(w_nmi_sync)
    );

    z80_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(PIN_INACTIVE)) u_sync_busrq (
        .i_clk(CLK), .i_rst_n(nRESET), .i_d(nBUSRQ_I), .o_q(nBUSRQ_S)
    );

    z80_sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rel (
        .i_clk(CLK), .i_rst_n(nRESET), .i_d(1'b1), .o_q(w_rel_sync)
    );

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    rst_state_e       r_state;
    rst_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_nreset_s;
    logic             r_rst_busy;

    // State, stretch counter and the two reset outputs; outputs are
    // registered from the next state so RUN and nRESET_S=1 coincide.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= S_RST_HOLD;
            r_cnt      <= CNT_ZERO;
            r_nreset_s <= 1'b0;
            r_rst_busy <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_nreset_s <= (w_state_nxt == S_RUN);
            r_rst_busy <= (w_state_nxt != S_RUN);
        end
    end

    // Next-state logic. The counter holds the stretch edges still to come;
    // the edge that takes it to zero is the edge that enters RUN, so the
    // release lands SYNC_STAGES+RST_STRETCH edges after nRESET rises.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RST_HOLD: begin
                w_state_nxt = S_RST_SYNC;
            end
            S_RST_SYNC: begin
                if (w_rel_sync) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (CNT_LOAD == CNT_ZERO) ? S_RUN : S_RST_STRETCH;
                end else begin
                    w_state_nxt = S_RST_SYNC;
                end
            end
            S_RST_STRETCH: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_RUN;
                end else if (r_cnt == CNT_ONE) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                    w_state_nxt = S_RST_STRETCH;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RST_HOLD;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign nRESET_S = r_nreset_s;
    assign rst_busy = r_rst_busy;

    // ------------------------------------------------------------------
    // nNMI path
    // ------------------------------------------------------------------
`ifdef Z80_NMI_FILTER_EN
    localparam int               FCNT_W    = (NMI_FILTER > 1) ? $clog2(NMI_FILTER) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(NMI_FILTER - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};

    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic              r_nmi_s;
    logic              w_nmi_nxt;

    // Filter state: run length of disagreeing samples and the filtered level.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_fcnt  <= FCNT_ZERO;
            r_nmi_s <= PIN_INACTIVE;
        end else begin
            r_fcnt  <= w_fcnt_nxt;
            r_nmi_s <= w_nmi_nxt;
        end
    end

    // The NMI_FILTER-th consecutive disagreeing sample is taken on its own
    // edge; the counter therefore never climbs past NMI_FILTER-1.
    always_comb begin
        w_fcnt_nxt = r_fcnt;
        w_nmi_nxt  = r_nmi_s;
        if (w_nmi_sync == r_nmi_s) begin
            w_fcnt_nxt = FCNT_ZERO;
        end else if (r_fcnt >= FCNT_LAST) begin
            w_nmi_nxt  = w_nmi_sync;
            w_fcnt_nxt = FCNT_ZERO;
        end else begin
            w_fcnt_nxt = r_fcnt + FCNT_ONE;
        end
    end

    assign nNMI_S = r_nmi_s;
`else
    // NMI_FILTER has no effect in this build.
    logic w_unused_nmi_filter;
    assign w_unused_nmi_filter = (NMI_FILTER > 0);

    assign nNMI_S = w_nmi_sync;
`endif

endmodule

// File: tb/tb_z80_input_cond.sv
module tb_z80_input_cond;

    localparam int S    = 2;
    localparam int R    = 8;
    localparam int F    = 4;
    localparam int MAXE = 8192;

    logic CLK, nRESET, nWAIT_I, nINT_I, nNMI_I, nBUSRQ_I;
    logic nWAIT_S, nINT_S, nNMI_S, nBUSRQ_S, nRESET_S, rst_busy;

    z80_input_cond #(.SYNC_STAGES(S), .RST_STRETCH(R), .NMI_FILTER(F)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .nWAIT_I(nWAIT_I), .nINT_I(nINT_I), .nNMI_I(nNMI_I), .nBUSRQ_I(nBUSRQ_I),
        .nWAIT_S(nWAIT_S), .nINT_S(nINT_S), .nNMI_S(nNMI_S), .nBUSRQ_S(nBUSRQ_S),
        .nRESET_S(nRESET_S), .rst_busy(rst_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: edges since reset release, input samples per edge,
    // and the filtered NMI level.
    int   n_edge  = 0;
    logic hist [0:3][0:MAXE-1];
    logic m_nmi   = 1'b1;

    typedef struct {
        logic w;
        logic b;
        logic ew;
        logic eb;
    } wb_vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Value of a synchroniser output just after edge k (idle high before edge 1).
    function automatic logic sync_after(input int sel, input int k);
        if (k >= 1 && k < MAXE) return hist[sel][k];
        else return 1'b1;
    endfunction

    task automatic model_edge();
        logic all_diff;
        if (nRESET && n_edge < MAXE - 1) begin
            n_edge++;
            hist[0][n_edge] = nWAIT_I;
            hist[1][n_edge] = nINT_I;
            hist[2][n_edge] = nNMI_I;
            hist[3][n_edge] = nBUSRQ_I;
            // Filter: change only when the last F pre-edge samples all differ.
            all_diff = 1'b1;
            for (int j = 0; j < F; j++) begin
                if (sync_after(2, n_edge - j - S) == m_nmi) all_diff = 1'b0;
            end
            if (all_diff) m_nmi = ~m_nmi;
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_nmi;
`ifdef Z80_NMI_FILTER_EN
        exp_nmi = m_nmi;
`else
        exp_nmi = sync_after(2, n_edge - S + 1);
`endif
        chk({tag, "/nWAIT_S"},  nWAIT_S,  sync_after(0, n_edge - S + 1));
        chk({tag, "/nINT_S"},   nINT_S,   sync_after(1, n_edge - S + 1));
        chk({tag, "/nNMI_S"},   nNMI_S,   exp_nmi);
        chk({tag, "/nBUSRQ_S"}, nBUSRQ_S, sync_after(3, n_edge - S + 1));
        chk({tag, "/nRESET_S"}, nRESET_S, logic'(n_edge >= S + R));
        chk({tag, "/rst_busy"}, rst_busy, logic'(n_edge < S + R));
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all(tag);
    endtask

    // Called just after a falling edge: assert reset mid-cycle and check at once.
    task automatic assert_reset(input string tag);
        #2;
        nRESET = 1'b0;
        n_edge = 0;
        m_nmi  = 1'b1;
        #1;
        check_all(tag);
    endtask

    task automatic release_reset();
        #2;
        nRESET = 1'b1;
    endtask

    // nNMI_I low a cycles, high g, low b, then high; count outcome over 30 edges.
    task automatic nmi_seq(input string name, input int a, input int g, input int b,
                           input int exp_first, input int exp_falls, input int exp_low);
        int   first = -1;
        int   falls = 0;
        int   lows  = 0;
        logic prev;
        prev = nNMI_S;
        for (int e = 1; e <= 30; e++) begin
            if (e <= a) nNMI_I = 1'b0;
            else if (e <= a + g) nNMI_I = 1'b1;
            else if (e <= a + g + b) nNMI_I = 1'b0;
            else nNMI_I = 1'b1;
            tick(name);
            if (prev && !nNMI_S) begin
                falls++;
                if (first < 0) first = e;
            end
            if (!nNMI_S) lows++;
            prev = nNMI_S;
        end
        chk_int({name, "/first_fall_edge"}, first, exp_first);
        chk_int({name, "/fall_count"}, falls, exp_falls);
        chk_int({name, "/low_cycles"}, lows, exp_low);
    endtask

    wb_vec_t wb_tab [0:8];

    initial begin
        nRESET = 1'b1; nWAIT_I = 1'b1; nINT_I = 1'b1; nNMI_I = 1'b1; nBUSRQ_I = 1'b1;
        wb_tab[0] = '{1'b1, 1'b1, 1'b1, 1'b1};
        wb_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
        wb_tab[2] = '{1'b0, 1'b0, 1'b0, 1'b0};
        wb_tab[3] = '{1'b1, 1'b1, 1'b0, 1'b0};
        wb_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        wb_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
        wb_tab[6] = '{1'b1, 1'b0, 1'b0, 1'b1};
        wb_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
        wb_tab[8] = '{1'b1, 1'b1, 1'b1, 1'b1};

        // Power-on reset, no clock edge needed for the reset values.
        #1;
        nRESET = 1'b0;
        #1;
        check_all("por");
        repeat (5) tick("por_hold");
        release_reset();
        for (int e = 1; e <= 12; e++) begin
            tick("por_release");
            chk("por_release_edge10", nRESET_S, logic'(e >= 10));
        end

        // Reset while running, then toggle nINT_I during the stretch.
        assert_reset("mid_reset");
        chk("mid_reset/nRESET_S_low", nRESET_S, 1'b0);
        repeat (3) tick("mid_hold");
        release_reset();
        for (int e = 1; e <= 12; e++) begin
            nINT_I = logic'(e % 2);
            tick("int_toggle");
            chk("int_toggle_release_edge10", nRESET_S, logic'(e >= 10));
            if (e >= 2) chk("int_toggle_track", nINT_S, logic'((e - 1) % 2));
            else chk("int_toggle_first", nINT_S, 1'b1);
        end
        nINT_I = 1'b1;
        repeat (4) tick("settle");

        // nWAIT/nBUSRQ two-edge latency, simultaneous changes.
        for (int i = 0; i < 9; i++) begin
            nWAIT_I  = wb_tab[i].w;
            nBUSRQ_I = wb_tab[i].b;
            tick("wb_table");
            chk($sformatf("wb_table[%0d]/nWAIT_S", i), nWAIT_S, wb_tab[i].ew);
            chk($sformatf("wb_table[%0d]/nBUSRQ_S", i), nBUSRQ_S, wb_tab[i].eb);
        end
        repeat (4) tick("settle");

        // nNMI pulse shapes.
`ifdef Z80_NMI_FILTER_EN
        nmi_seq("nmi_low1", 1, 0, 0, -1, 0, 0);
        nmi_seq("nmi_low3", 3, 0, 0, -1, 0, 0);
        nmi_seq("nmi_low4", 4, 0, 0, 6, 1, 4);
        nmi_seq("nmi_glitch", 6, 2, 6, 6, 1, 14);
`else
        nmi_seq("nmi_low1", 1, 0, 0, 2, 1, 1);
        nmi_seq("nmi_low3", 3, 0, 0, 2, 1, 3);
        nmi_seq("nmi_low4", 4, 0, 0, 2, 1, 4);
        nmi_seq("nmi_glitch", 6, 2, 6, 2, 2, 12);
`endif

        // Randomised traffic with occasional mid-run resets.
        for (int c = 0; c < 1500; c++) begin
            nWAIT_I = logic'($urandom_range(0, 1));
            nINT_I  = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) nNMI_I = ~nNMI_I;
            if ($urandom_range(0, 2) == 0) nBUSRQ_I = ~nBUSRQ_I;
            if ($urandom_range(0, 299) == 0) begin
                assert_reset("rand_reset");
                repeat ($urandom_range(1, 3)) tick("rand_hold");
                release_reset();
            end
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
